// File: rtl/adda_pkg.sv
// Shared types and constants for the ADC-driven frequency/amplitude meter.
package adda_pkg;

  localparam int unsigned ADC_W  = 8;
  localparam int unsigned FREQ_W = 20;
  localparam int unsigned EDGE_W = 21;

  localparam logic [FREQ_W-1:0] FREQ_MAX = 20'd999_999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GATE  = ST_GATE,
    LATCH = ST_LATCH
  } state_e;

  // Result of one closed gate window, as presented to the display path.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [ADC_W-1:0]  vpp;
    logic              ovf;
  } meas_result_t;

  function automatic logic [ADC_W-1:0] sat_add(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ADC_W] ? {ADC_W{1'b1}} : s[ADC_W-1:0];
  endfunction

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[ADC_W] ? {ADC_W{1'b0}} : s[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/schmitt_edge_det.sv
// Schmitt trigger around a movable threshold; pulses rise on each LOW->HIGH flip.
module schmitt_edge_det
  import adda_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [ADC_W-1:0] data,
  input  logic [ADC_W-1:0] thr,
  input  logic [ADC_W-1:0] hyst,
  output logic             rise
);

  logic             high_q;
  logic             high_d;
  logic [ADC_W-1:0] thr_hi;
  logic [ADC_W-1:0] thr_lo;

  // rise is combinational so a sample in the same cycle is counted immediately
  always_comb begin
    thr_hi = sat_add(thr, hyst);
    thr_lo = sat_sub(thr, hyst);
    high_d = high_q;
    rise   = 1'b0;
    if (valid) begin
      if (!high_q && (data >= thr_hi)) begin
        high_d = 1'b1;
        rise   = 1'b1;
      end else if (high_q && (data <= thr_lo)) begin
        high_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) high_q <= 1'b0;
    else        high_q <= high_d;
  end

endmodule

// File: rtl/wave_freq_meter.sv
// Gate-counting frequency meter with peak-to-peak amplitude and adaptive threshold.
// Build option FREQ_AVG_EN: freq_hz becomes a 3:1 running average of window results.
module wave_freq_meter
  import adda_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned HYST        = 8,
  parameter int unsigned THR_INIT    = 128
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              meas_en,
  input  logic              sample_valid,
  input  logic [ADC_W-1:0]  sample_data,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [ADC_W-1:0]  vpp,
  output logic              freq_valid,
  output logic              freq_ovf
);

  localparam int unsigned GCW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned SUM_W = FREQ_W + 2;
  localparam logic [GCW-1:0]   GATE_LAST  = GCW'(GATE_CYCLES - 1);
  localparam logic [ADC_W-1:0] HYST_C     = ADC_W'(HYST);
  localparam logic [ADC_W-1:0] THR_INIT_C = ADC_W'(THR_INIT);
  localparam logic [EDGE_W-1:0] EDGE_LIM  = EDGE_W'(FREQ_MAX);

  state_e            state_q;
  logic [GCW-1:0]    gate_cnt_q;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [ADC_W-1:0]  max_q, max_d;
  logic [ADC_W-1:0]  min_q, min_d;
  logic [ADC_W-1:0]  thr_q, thr_mid;
  logic              freq_valid_q;
  meas_result_t      res_q, res_d;
  logic              smp_ok, rise, seen;
  logic [FREQ_W-1:0] new_sat;
  logic [SUM_W-1:0]  avg_sum;
  logic [ADC_W:0]    mid_sum;

  schmitt_edge_det u_schmitt (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .valid (smp_ok),
    .data  (sample_data),
    .thr   (thr_q),
    .hyst  (HYST_C),
    .rise  (rise)
  );

  // Window accumulators including the current cycle's sample, so a strobe in
  // the terminal gate cycle lands in the closing window.
  always_comb begin
    smp_ok     = sample_valid && (state_q == GATE);
    edge_cnt_d = (rise && (edge_cnt_q != {EDGE_W{1'b1}})) ? edge_cnt_q + EDGE_W'(1) : edge_cnt_q;
    max_d      = (smp_ok && (sample_data > max_q)) ? sample_data : max_q;
    min_d      = (smp_ok && (sample_data < min_q)) ? sample_data : min_q;
    seen       = (max_d >= min_d);
    mid_sum    = {1'b0, max_d} + {1'b0, min_d};
    thr_mid    = ADC_W'(mid_sum >> 1);
    new_sat    = (edge_cnt_d > EDGE_LIM) ? FREQ_MAX : edge_cnt_d[FREQ_W-1:0];
    avg_sum    = '0;
`ifdef FREQ_AVG_EN
    avg_sum    = SUM_W'(res_q.freq) * SUM_W'(3) + SUM_W'(new_sat);
    res_d.freq = FREQ_W'(avg_sum >> 2);
`else
    res_d.freq = new_sat;
`endif
    res_d.vpp  = seen ? (max_d - min_d) : '0;
    res_d.ovf  = (edge_cnt_d > EDGE_LIM);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      max_q        <= '0;
      min_q        <= '1;
      thr_q        <= THR_INIT_C;
      res_q        <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      freq_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          max_q      <= '0;
          min_q      <= '1;
          if (meas_en) state_q <= GATE;
        end
        GATE: begin
          if (!meas_en) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            max_q      <= '0;
            min_q      <= '1;
          end else if (gate_cnt_q == GATE_LAST) begin
            state_q      <= LATCH;
            res_q        <= res_d;
            freq_valid_q <= 1'b1;
            if (seen) thr_q <= thr_mid;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            max_q        <= '0;
            min_q        <= '1;
          end else begin
            gate_cnt_q <= gate_cnt_q + GCW'(1);
            edge_cnt_q <= edge_cnt_d;
            max_q      <= max_d;
            min_q      <= min_d;
          end
        end
        LATCH: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          max_q      <= '0;
          min_q      <= '1;
          state_q    <= meas_en ? GATE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freq_hz    = res_q.freq;
  assign vpp        = res_q.vpp;
  assign freq_ovf   = res_q.ovf;
  assign freq_valid = freq_valid_q;

endmodule

// File: tb/tb_wave_freq_meter.sv
// Directed bench for wave_freq_meter with a 1000-cycle gate window.
module tb_wave_freq_meter;
  import adda_pkg::*;

  localparam int unsigned GC = 1000;
  localparam int M_NOISE  = 0;
  localparam int M_SQUARE = 1;
  localparam int M_TERM   = 2;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        meas_en;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic [19:0] freq_hz;
  logic [7:0]  vpp;
  logic        freq_valid;
  logic        freq_ovf;

  int n_cmp;
  int n_bad;
  int model;
  int sp;
  int pulses;
  int noise [8] = '{-5, 3, 5, -2, -5, 4, 0, 5};

  wave_freq_meter #(
    .GATE_CYCLES (GC),
    .HYST        (8),
    .THR_INIT    (128)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .meas_en      (meas_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .freq_hz      (freq_hz),
    .vpp          (vpp),
    .freq_valid   (freq_valid),
    .freq_ovf     (freq_ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  function automatic int avg(input int prev, input int nw);
`ifdef FREQ_AVG_EN
    return (3 * prev + nw) >> 2;
`else
    return nw + 0 * prev;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One gate cycle of stimulus for waveform 'mode' at window offset j.
  task automatic drive(input int mode, input int j);
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    case (mode)
      M_NOISE: if (j % 10 == 0) begin
        sample_valid = 1'b1;
        sample_data  = 8'(128 + noise[(j / 10) % 8]);
      end
      M_SQUARE: if (j % 20 == 0) begin
        sample_valid = 1'b1;
        sample_data  = ((j / 100) % 2 == 0) ? 8'd20 : 8'd230;
      end
      default: if (j == 999) begin
        sample_valid = 1'b1;
        sample_data  = 8'd230;
      end else if (j % 20 == 0) begin
        sample_valid = 1'b1;
        sample_data  = (j >= 900 || (j / 100) % 2 == 0) ? 8'd20 : 8'd230;
      end
    endcase
    tick();
  endtask

  // Entry edge (from IDLE or LATCH, carrying a strobe that must be ignored), then ncyc gate cycles.
  task automatic run_window(input int mode, input int ncyc, output int spurious);
    spurious = 0;
    sample_valid = 1'b1;
    sample_data  = 8'd250;
    tick();
    for (int j = 0; j < ncyc; j++) begin
      drive(mode, j);
      if (j < ncyc - 1 && freq_valid !== 1'b0) spurious++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model = 0;
    sys_rst_n    = 1'b0;
    meas_en      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    tick();
    tick();
    chk("rst_freq", 32'(freq_hz), 0);
    chk("rst_vpp", 32'(vpp), 0);
    chk("rst_valid", 32'(freq_valid), 0);
    chk("rst_ovf", 32'(freq_ovf), 0);
    chk("rst_thr", 32'(dut.thr_q), 128);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    sys_rst_n = 1'b1;
    tick();
    chk("idle_no_pulse", 32'(freq_valid), 0);

    // Noise of +-5 codes around 128 never clears the 120/136 hysteresis band
    meas_en = 1'b1;
    run_window(M_NOISE, GC, sp);
    model = avg(model, 0);
    chk("noise_spurious", 32'(sp), 0);
    chk("noise_valid", 32'(freq_valid), 1);
    chk("noise_freq", 32'(freq_hz), 32'(model));
    chk("noise_vpp", 32'(vpp), 10);
    chk("noise_thr", 32'(dut.thr_q), 128);

    // Back-to-back window: 20/230 square, five periods
    run_window(M_SQUARE, GC, sp);
    model = avg(model, 5);
    chk("sq_spurious", 32'(sp), 0);
    chk("sq_valid", 32'(freq_valid), 1);
    chk("sq_freq", 32'(freq_hz), 32'(model));
    chk("sq_vpp", 32'(vpp), 210);
    chk("sq_ovf", 32'(freq_ovf), 0);
    chk("sq_thr", 32'(dut.thr_q), 125);

    // Four crossings inside the window plus one on the terminal-cycle strobe
    run_window(M_TERM, GC, sp);
    model = avg(model, 5);
    chk("term_spurious", 32'(sp), 0);
    chk("term_valid", 32'(freq_valid), 1);
    chk("term_freq", 32'(freq_hz), 32'(model));
    chk("term_vpp", 32'(vpp), 210);

    meas_en      = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("pulse_width", 32'(freq_valid), 0);
    chk("latch_to_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Abort at gate_cnt=400
    meas_en = 1'b1;
    run_window(M_SQUARE, 400, sp);
    meas_en      = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    pulses = sp;
    for (int k = 0; k < 5; k++) begin
      if (freq_valid !== 1'b0) pulses++;
      tick();
    end
    chk("abort_no_pulse", 32'(pulses), 0);
    chk("abort_freq_hold", 32'(freq_hz), 32'(model));
    chk("abort_vpp_hold", 32'(vpp), 210);
    chk("abort_thr_hold", 32'(dut.thr_q), 125);

    // Re-enable: a full window is needed before the next pulse
    meas_en = 1'b1;
    run_window(M_SQUARE, GC, sp);
    model = avg(model, 5);
    chk("reen_spurious", 32'(sp), 0);
    chk("reen_valid", 32'(freq_valid), 1);
    chk("reen_freq", 32'(freq_hz), 32'(model));
    chk("reen_vpp", 32'(vpp), 210);

    // Reset in the middle of the following window
    run_window(M_SQUARE, 300, sp);
    chk("mid_spurious", 32'(sp), 0);
    chk("mid_freq_before_rst", 32'(freq_hz), 32'(model));
    sys_rst_n = 1'b0;
    tick();
    chk("mrst_freq", 32'(freq_hz), 0);
    chk("mrst_vpp", 32'(vpp), 0);
    chk("mrst_valid", 32'(freq_valid), 0);
    chk("mrst_ovf", 32'(freq_ovf), 0);
    chk("mrst_thr", 32'(dut.thr_q), 128);
    chk("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mrst_edge_cnt", 32'(dut.edge_cnt_q), 0);

    sys_rst_n    = 1'b1;
    meas_en      = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wave_freq_meter.md
Name: wave_freq_meter

Overview:
- Measures the frequency and peak-to-peak amplitude of the waveform digitised by the I2C ADC read path.
- Consumes 8-bit ADC samples, qualified by the per-transfer completion strobe from the I2C controller read path.
- Produces a 20-bit binary Hz value for the dynamic 7-segment driver, plus an amplitude byte.
- Frequency measurement is gate-counting of hysteresis-qualified rising crossings of an adaptive midpoint threshold.

Parameters:
- GATE_CYCLES, 50_000_000: gate window length in sys_clk cycles (1 s at 50 MHz). Benches override it small.
- HYST, 8: Schmitt hysteresis half-width, in ADC codes.
- THR_INIT, 128: threshold used before the first completed window.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  synchronous active-low reset.
- meas_en  input  1  measurement enable. Level-sensitive.
- sample_valid  input  1  one-cycle strobe; sample_data is valid in that cycle.
- sample_data  input  8  ADC code.
- freq_hz  output  20  last measured frequency in Hz, saturated at 999_999.
- vpp  output  8  max-min of the last window.
- freq_valid  output  1  one-cycle pulse when freq_hz/vpp update.
- freq_ovf  output  1  high while the last window saturated.

Behaviour:
- Interface: one clock, sys_clk. Reset is synchronous and active-low (sys_rst_n sampled on the sys_clk rising edge only).
- Reset values:
  - Outputs: freq_hz=0, vpp=0, freq_valid=0, freq_ovf=0.
  - Internal: thr=THR_INIT, gate_cnt=0, edge_cnt=0, max=0, min=255, schmitt=LOW, state=IDLE.
- FSM: IDLE, GATE, LATCH.
  - IDLE: counters held cleared. Enters GATE when meas_en=1.
  - GATE: gate_cnt increments every cycle. At gate_cnt==GATE_CYCLES-1, next state is LATCH. If meas_en=0 in any cycle, go to IDLE: window aborted, outputs hold, thr holds.
  - LATCH: single cycle. Registers are updated as follows:
    - freq_hz = min(edge_cnt, 999_999).
    - freq_ovf = (edge_cnt > 999_999).
    - vpp = max-min. If no sample arrived in the window, vpp=0.
    - thr = (max+min)>>1, computed at 9-bit width. If no sample arrived, thr holds.
    - freq_valid=1 for this cycle.
    - gate_cnt, edge_cnt, max, min are cleared.
    - Next state is GATE if meas_en=1, else IDLE.
  - freq_valid is therefore high exactly one cycle, GATE_CYCLES cycles after GATE entry. Steady-state period is GATE_CYCLES+1.
- Sample processing (only in GATE, on sample_valid):
  - max/min update.
  - Schmitt LOW->HIGH when sample_data >= sat255(thr+HYST). HIGH->LOW when sample_data <= sat0(thr-HYST).
  - Each LOW->HIGH transition increments edge_cnt. edge_cnt is 21 bits and saturates at all-ones.
- Boundaries:
  - A sample strobe coinciding with the terminal gate cycle belongs to the closing window.
  - A strobe during LATCH or IDLE is ignored.
  - Schmitt state is retained across windows and reset only by sys_rst_n.
  - Reset mid-window: returns to the reset values above on the next edge.

Optional Feature:
- Macro: FREQ_AVG_EN.
- Defined: in LATCH, freq_hz = (3*freq_hz + new_sat) >> 2, using 22-bit intermediate arithmetic. freq_ovf is still derived from the raw edge_cnt. The first window after reset averages with freq_hz=0.
- Undefined: freq_hz = new_sat directly, as specified above.

Decomposition:
- Shared package adda_pkg holds:
  - ADC_W=8.
  - FREQ_MAX=20'd999_999.
  - State encoding localparams for IDLE/GATE/LATCH.
- Sub-module schmitt_edge_det holds:
  - Inputs: clk, rst_n, valid, data, thr, hyst.
  - Output: rise pulse.
  - Contents: the threshold saturation and LOW/HIGH state.

Test Plan:
- GATE_CYCLES=1000. Square wave alternating 20/230, 5 full periods per window, strobe every 20 cycles -> freq_valid at cycle 1000 after meas_en. Then freq_hz=5, vpp=210, thr becomes 125.
- Sine-ish samples with ±5-code noise around 128 and HYST=8, no real crossings -> freq_hz=0, no spurious edges counted.
- Terminal-cycle strobe that completes a LOW->HIGH crossing -> counted in the closing window (freq_hz=N+1), not in the next window.
- meas_en dropped at gate_cnt=400 -> no freq_valid, outputs unchanged. Re-enable -> full 1000-cycle window before the next freq_valid.
- Reset asserted mid-window with freq_hz=5 -> next cycle all outputs 0, thr=128, state IDLE.
- FREQ_AVG_EN defined, two windows measuring 8 then 8 -> freq_hz=2 then 3.
